// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: command and display front end for the stopwatch event counter.
//
// Debounces the start/pause/stop buttons, runs the IDLE/RUN/PAUSED state
// machine, emits one-cycle command flags, generates the prescaled count tick
// in RUN, and converts the returned count to 5-digit BCD with a free-running
// sequential double-dabble converter.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   asynchronous active-low reset
//   btn_start    in   raw start button (async, active-high)
//   btn_pause    in   raw pause button (async, active-high)
//   btn_stop     in   raw stop button (async, active-high)
//   cnt_events   in   [15:0] current count from the counter
//   flags        out  [7:0] one-cycle command: 01 START, 02 PAUSE, 04 STOP
//   active_event out  one-cycle count tick, RUN only
//   run_state    out  [1:0] 0 IDLE, 1 RUN, 2 PAUSED
//   bcd          out  [19:0] {d4,d3,d2,d1,d0} of the last converted count
//   bcd_valid    out  one-cycle pulse when bcd updates
module stopwatch_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned TICK_DIV   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_stop,
  input  logic [15:0] cnt_events,
  output logic [7:0]  flags,
  output logic        active_event,
  output logic [1:0]  run_state,
  output logic [19:0] bcd,
  output logic        bcd_valid
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPaused = 2'd2} run_state_e;
  typedef enum logic [1:0] {CvSample, CvShift, CvLoad} conv_state_e;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers; bit 0 start, 1 pause, 2 stop
  // ---------------------------------------------------------------------------
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q, deb_d, deb_prev_q;
  logic [DebW-1:0] deb_cnt_q [3];
  logic [DebW-1:0] deb_cnt_d [3];
  logic [2:0]      press;

  assign btn_raw = {btn_stop, btn_pause, btn_start};

  // The counter only runs while the synchronised input disagrees with the
  // debounced level, so any bounce back to the old level restarts the window.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run-state FSM, command flags and tick prescaler
  // ---------------------------------------------------------------------------
  run_state_e    state_q, state_d;
  logic [7:0]    flags_q, flags_d;
  logic          tick_q, tick_d;
  logic [PreW-1:0] pre_q, pre_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Highest-priority press wins: stop > pause > start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (press[0] && !press[1] && !press[2]) state_d = StRun;
      end
      StRun: begin
        if (press[2])      state_d = StIdle;
        else if (press[1]) state_d = StPaused;
      end
      StPaused: begin
        if (press[2])                  state_d = StIdle;
        else if (!press[1] && press[0]) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // The prescaler counts every cycle spent in RUN, including the cycle a
  // pause/stop is detected; a wrap in that cycle produces no tick.
  always_comb begin
    flags_d = 8'h00;
    tick_d  = 1'b0;
    pre_d   = pre_q;
    if (state_d != state_q) begin
      case (state_d)
        StRun:    flags_d = 8'h01;
        StPaused: flags_d = 8'h02;
        StIdle:   flags_d = 8'h04;
        default:  flags_d = 8'h00;
      endcase
    end
    if (state_d == StIdle) begin
      pre_d = '0;
    end else if (state_q == StRun) begin
      if (pre_q == PreLast) begin
        pre_d  = '0;
        tick_d = (state_d == StRun);
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 8'h00;
      tick_q  <= 1'b0;
      pre_q   <= '0;
    end else begin
      flags_q <= flags_d;
      tick_q  <= tick_d;
      pre_q   <= pre_d;
    end
  end

  assign flags        = flags_q;
  assign active_event = tick_q;
  assign run_state    = state_q;

  // ---------------------------------------------------------------------------
  // Double-dabble converter: 1 sample + 16 shifts + 1 load = 18-cycle period
  // ---------------------------------------------------------------------------
  conv_state_e conv_q, conv_d;
  logic [35:0] shreg_q, shreg_d, adj;   // {bcd[19:0], bin[15:0]}
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic        bcd_valid_q, bcd_valid_d;

  always_comb begin
    conv_d = conv_q;
    case (conv_q)
      CvSample: conv_d = CvShift;
      CvShift:  if (bit_cnt_q == 4'd15) conv_d = CvLoad;
      CvLoad:   conv_d = CvSample;
      default:  conv_d = CvSample;
    endcase
  end

  always_comb begin
    adj = shreg_q;
    for (int d = 0; d < 5; d++) begin
      if (shreg_q[16+4*d +: 4] >= 4'd5) adj[16+4*d +: 4] = shreg_q[16+4*d +: 4] + 4'd3;
    end
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    case (conv_q)
      CvSample: begin
        shreg_d   = {20'd0, cnt_events};
        bit_cnt_d = 4'd0;
      end
      CvShift: begin
        shreg_d   = adj << 1;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      CvLoad: begin
        bcd_d       = shreg_q[35:16];
        bcd_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_q      <= CvSample;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      conv_q      <= conv_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl (DEB_CYCLES=50, TICK_DIV=100).
module tb_stopwatch_ctrl;

  localparam int DEB  = 50;
  localparam int TICK = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_pause, btn_stop;
  logic [15:0] cnt_events;
  logic [7:0]  flags;
  logic        active_event;
  logic [1:0]  run_state;
  logic [19:0] bcd;
  logic        bcd_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = DEB + 3;

  // Event monitor: single writer of everything below.
  int         cyc = 0;
  int         n_flags = 0;
  logic [7:0] last_flag = 8'h00;
  int         last_flag_cyc = 0;
  int         n_ticks = 0;
  int         tick_at [0:1023];

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEB_CYCLES(DEB),
    .TICK_DIV  (TICK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .btn_stop    (btn_stop),
    .cnt_events  (cnt_events),
    .flags       (flags),
    .active_event(active_event),
    .run_state   (run_state),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (flags != 8'h00) begin
      n_flags       <= n_flags + 1;
      last_flag     <= flags;
      last_flag_cyc <= cyc + 1;
    end
    if (active_event && n_ticks < 1024) begin
      tick_at[n_ticks] <= cyc + 1;
      n_ticks          <= n_ticks + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic hold_buttons(input logic s, input logic p, input logic t);
    btn_stop = s; btn_pause = p; btn_start = t;
    step(DEB + 10);
    btn_stop = 1'b0; btn_pause = 1'b0; btn_start = 1'b0;
    step(DEB + 10);
  endtask

  task automatic wait_flag(input int base, input string name);
    int k;
    k = 0;
    while (n_flags == base && k < DEB + 10) begin step(1); k++; end
    n_tests++;
    if (n_flags == base) begin
      n_fail++;
      $display("FAIL %s: no flag within %0d cycles, one required", name, k);
    end
  endtask

  task automatic wait_tick(input int base, input string name);
    int k;
    k = 0;
    while (n_ticks == base && k < 2 * TICK + 5) begin step(1); k++; end
    n_tests++;
    if (n_ticks == base) begin
      n_fail++;
      $display("FAIL %s: no tick within %0d cycles, one required", name, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; btn_stop = 1'b0; cnt_events = 16'd0;
    step(3);
    n_tests += 5;
    if (flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h want 00", flags); end
    if (active_event !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick: got %b want 0", active_event);
    end
    if (run_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", run_state); end
    if (bcd !== 20'h0) begin n_fail++; $display("FAIL reset_bcd: got %h want 00000", bcd); end
    if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bcd_valid); end
    rst = 1'b1;
    step(2);
  endtask

  task automatic test_start();
    int bf, bt, drive, fc;
    bf = n_flags; bt = n_ticks; drive = cyc;
    btn_start = 1'b1;
    wait_flag(bf, "start_flag");
    fc  = last_flag_cyc;
    lat = fc - drive;
    n_tests += 3;
    if (last_flag !== 8'h01) begin n_fail++; $display("FAIL start_value: got %h want 01", last_flag); end
    if (lat < DEB || lat > DEB + 5) begin
      n_fail++; $display("FAIL start_latency: got %0d want %0d..%0d", lat, DEB, DEB + 5);
    end
    if (run_state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", run_state); end
    while (cyc < fc + 2 * TICK + 10) step(1);
    n_tests += 4;
    if (n_flags - bf != 1) begin n_fail++; $display("FAIL hold_one_press: got %0d want 1", n_flags - bf); end
    if (n_ticks - bt != 2) begin n_fail++; $display("FAIL tick_count: got %0d want 2", n_ticks - bt); end
    if (tick_at[bt] - fc != TICK) begin
      n_fail++; $display("FAIL first_tick: got %0d want %0d", tick_at[bt] - fc, TICK);
    end
    if (tick_at[bt+1] - tick_at[bt] != TICK) begin
      n_fail++; $display("FAIL tick_period: got %0d want %0d", tick_at[bt+1] - tick_at[bt], TICK);
    end
    btn_start = 1'b0;
    step(DEB + 10);
    n_tests++;
    if (n_flags - bf != 1) begin n_fail++; $display("FAIL release_flag: got %0d want 1", n_flags - bf); end
  endtask

  task automatic test_bounce();
    int bf, mid;
    hold_buttons(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (run_state !== 2'd0) begin n_fail++; $display("FAIL bounce_setup: got %0d want 0", run_state); end
    bf = n_flags;
    btn_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(10);
      btn_start = ~btn_start;
    end
    mid = n_flags - bf;
    step(DEB + 10);
    btn_start = 1'b0;
    step(DEB + 10);
    n_tests += 4;
    if (mid != 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d want 0", mid); end
    if (n_flags - bf != 1) begin n_fail++; $display("FAIL bounce_once: got %0d want 1", n_flags - bf); end
    if (last_flag !== 8'h01) begin n_fail++; $display("FAIL bounce_value: got %h want 01", last_flag); end
    if (run_state !== 2'd1) begin n_fail++; $display("FAIL bounce_state: got %0d want 1", run_state); end
  endtask

  task automatic test_pause_resume();
    int bt, bf, t, pf, rf;
    bt = n_ticks;
    wait_tick(bt, "pause_sync_tick");
    t = tick_at[bt];
    while (cyc < t + TICK + 40 - lat) step(1);
    bf = n_flags;
    btn_pause = 1'b1;
    wait_flag(bf, "pause_flag");
    pf = last_flag_cyc;
    bt = n_ticks;
    n_tests += 3;
    if (last_flag !== 8'h02) begin n_fail++; $display("FAIL pause_value: got %h want 02", last_flag); end
    if (pf != t + TICK + 40) begin n_fail++; $display("FAIL pause_phase: got %0d want 40", pf - t - TICK); end
    if (run_state !== 2'd2) begin n_fail++; $display("FAIL pause_state: got %0d want 2", run_state); end
    step(DEB + 10);
    btn_pause = 1'b0;
    while (cyc < pf + 500 - lat) step(1);
    n_tests++;
    if (n_ticks != bt) begin n_fail++; $display("FAIL paused_ticks: got %0d want 0", n_ticks - bt); end
    bf = n_flags;
    btn_start = 1'b1;
    wait_flag(bf, "resume_flag");
    rf = last_flag_cyc;
    bt = n_ticks;
    n_tests += 3;
    if (last_flag !== 8'h01) begin n_fail++; $display("FAIL resume_value: got %h want 01", last_flag); end
    if (rf != pf + 500) begin n_fail++; $display("FAIL resume_time: got %0d want 500", rf - pf); end
    if (run_state !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d want 1", run_state); end
    wait_tick(bt, "resume_tick");
    n_tests++;
    if (tick_at[bt] - rf != TICK - 40) begin
      n_fail++; $display("FAIL resume_partial: got %0d want %0d", tick_at[bt] - rf, TICK - 40);
    end
    btn_start = 1'b0;
    step(DEB + 10);
  endtask

  task automatic test_simultaneous();
    int bt, bf, t, sf, rf;
    bt = n_ticks;
    wait_tick(bt, "stop_sync_tick");
    t = tick_at[bt];
    // Stop flag lands exactly where the next tick would have been.
    while (cyc < t + TICK - lat) step(1);
    bf = n_flags;
    bt = n_ticks;
    btn_start = 1'b1; btn_pause = 1'b1; btn_stop = 1'b1;
    wait_flag(bf, "stop_flag");
    sf = last_flag_cyc;
    n_tests += 3;
    if (last_flag !== 8'h04) begin n_fail++; $display("FAIL stop_value: got %h want 04", last_flag); end
    if (sf != t + TICK) begin n_fail++; $display("FAIL stop_time: got %0d want %0d", sf - t, TICK); end
    if (run_state !== 2'd0) begin n_fail++; $display("FAIL stop_state: got %0d want 0", run_state); end
    step(DEB + 10);
    btn_start = 1'b0; btn_pause = 1'b0; btn_stop = 1'b0;
    step(DEB + 10);
    n_tests += 2;
    if (n_flags - bf != 1) begin n_fail++; $display("FAIL stop_only: got %0d want 1", n_flags - bf); end
    if (n_ticks != bt) begin n_fail++; $display("FAIL stop_no_tick: got %0d want 0", n_ticks - bt); end
    bf = n_flags;
    btn_start = 1'b1;
    wait_flag(bf, "restart_flag");
    rf = last_flag_cyc;
    bt = n_ticks;
    wait_tick(bt, "restart_tick");
    n_tests++;
    if (tick_at[bt] - rf != TICK) begin
      n_fail++; $display("FAIL restart_tick_gap: got %0d want %0d", tick_at[bt] - rf, TICK);
    end
    btn_start = 1'b0;
    step(DEB + 10);
  endtask

  task automatic test_bcd();
    logic [15:0] vin  [7];
    logic [19:0] vexp [7];
    int k;
    vin  = '{16'd65535, 16'd0, 16'd12345, 16'd9, 16'd10000, 16'd40960, 16'd99};
    vexp = '{20'h65535, 20'h00000, 20'h12345, 20'h00009, 20'h10000, 20'h40960, 20'h00099};
    for (int i = 0; i < 7; i++) begin
      cnt_events = vin[i];
      k = 0;
      while (!bcd_valid && k < 40) begin step(1); k++; end
      step(1);
      k = 1;
      while (!bcd_valid && k < 40) begin step(1); k++; end
      n_tests += 2;
      if (k != 18) begin n_fail++; $display("FAIL bcd_period[%0d]: got %0d want 18", i, k); end
      if (bcd !== vexp[i]) begin n_fail++; $display("FAIL bcd_value[%0d]: got %h want %h", i, bcd, vexp[i]); end
      step(9);
      n_tests++;
      if (bcd !== vexp[i] || bcd_valid !== 1'b0) begin
        n_fail++; $display("FAIL bcd_hold[%0d]: got %h/%b want %h/0", i, bcd, bcd_valid, vexp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int k, bf, bt;
    cnt_events = 16'd65535;
    for (int j = 0; j < 2; j++) begin
      k = 0;
      while (!bcd_valid && k < 40) begin step(1); k++; end
      step(1);
    end
    step(5);
    bt = n_ticks;
    wait_tick(bt, "reset_sync_tick");
    #2 rst = 1'b0;
    #1;
    n_tests += 5;
    if (flags !== 8'h00) begin n_fail++; $display("FAIL arst_flags: got %h want 00", flags); end
    if (active_event !== 1'b0) begin
      n_fail++; $display("FAIL arst_tick: got %b want 0", active_event);
    end
    if (run_state !== 2'd0) begin n_fail++; $display("FAIL arst_state: got %0d want 0", run_state); end
    if (bcd !== 20'h0) begin n_fail++; $display("FAIL arst_bcd: got %h want 00000", bcd); end
    if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", bcd_valid); end
    step(2);
    bf = n_flags;
    rst = 1'b1;
    k = 0;
    while (!bcd_valid && k < 40) begin step(1); k++; end
    n_tests += 4;
    if (k != 18) begin n_fail++; $display("FAIL arst_conv_restart: got %0d want 18", k); end
    if (bcd !== 20'h65535) begin n_fail++; $display("FAIL arst_bcd_after: got %h want 65535", bcd); end
    if (run_state !== 2'd0) begin n_fail++; $display("FAIL arst_idle_after: got %0d want 0", run_state); end
    if (n_flags != bf) begin n_fail++; $display("FAIL arst_no_flags: got %0d want 0", n_flags - bf); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_pause_resume();
    test_simultaneous();
    test_bcd();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, completion required");
    $fatal(1, "watchdog");
  end

endmodule
